// File: rtl/spi_mode_master.sv
// SPI master supporting all four CPOL/CPHA modes with a per-frame mode latch,
// a delayed MISO capture for round-trip compensation and equal-delay pad registers.
module spi_mode_master #(
  parameter int unsigned CLKDIV    = 4,
  parameter int unsigned BITWIDTH  = 8,
  parameter int unsigned MSB_FIRST = 1,
  parameter int unsigned RT_DELAY  = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                tx_valid,
  output logic                tx_ready,
  input  logic [BITWIDTH-1:0] tx_data,
  input  logic                cpol,
  input  logic                cpha,
  output logic                rx_valid,
  output logic [BITWIDTH-1:0] rx_data,
  output logic                pad_spi_clk_o,
  output logic                pad_spi_cs_n_o,
  output logic                pad_spi_dout,
  input  logic                pad_spi_din
);

  localparam int unsigned H  = CLKDIV / 2;
  localparam int unsigned CW = $clog2(CLKDIV + 1);
  localparam int unsigned EW = $clog2(2 * BITWIDTH + 1);

  localparam logic [CW-1:0] HLast = CW'(H - 1);
  localparam logic [CW-1:0] RLast = CW'(RT_DELAY);
  localparam logic [EW-1:0] ELast = EW'(2 * BITWIDTH);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] LEAD  = 3'd1;
  localparam logic [2:0] XFER  = 3'd2;
  localparam logic [2:0] TRAIL = 3'd3;
  localparam logic [2:0] GAP   = 3'd4;

  logic [2:0]          state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [EW-1:0]       ecnt_q, ecnt_d;
  logic                cpol_l_q, cpol_l_d, cpha_l_q, cpha_l_d;
  logic [BITWIDTH-1:0] tx_sr_q, tx_sr_d, rx_sr_q, rx_sr_d;
  logic [BITWIDTH-1:0] rx_data_q, rx_data_d;
  logic                rx_valid_q, rx_valid_d, tx_ready_q, tx_ready_d;
  logic                cs_n_q, cs_n_d, sclk_q, sclk_d, dout_q, dout_d;
  logic                pend_q, pend_d;
  logic [CW-1:0]       dly_q, dly_d;
  logic                din_q;
  logic                pad_clk_q, pad_cs_n_q, pad_dout_q;
  logic                tick, samp, drive, cap;

  function automatic logic head_bit(input logic [BITWIDTH-1:0] v);
    return (MSB_FIRST != 0) ? v[BITWIDTH-1] : v[0];
  endfunction

  function automatic logic [BITWIDTH-1:0] shift_out(input logic [BITWIDTH-1:0] v);
    return (MSB_FIRST != 0) ? {v[BITWIDTH-2:0], 1'b0} : {1'b0, v[BITWIDTH-1:1]};
  endfunction

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ecnt_d     = ecnt_q;
    cpol_l_d   = cpol_l_q;
    cpha_l_d   = cpha_l_q;
    tx_sr_d    = tx_sr_q;
    rx_sr_d    = rx_sr_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    tx_ready_d = tx_ready_q;
    cs_n_d     = cs_n_q;
    sclk_d     = sclk_q;
    dout_d     = dout_q;
    pend_d     = pend_q;
    dly_d      = dly_q;
    tick       = 1'b0;
    samp       = 1'b0;
    drive      = 1'b0;
    cap        = 1'b0;

    case (state_q)
      IDLE: begin
        sclk_d     = cpol;
        tx_ready_d = 1'b1;
        if (tx_valid && tx_ready_q) begin
          state_d    = LEAD;
          tx_ready_d = 1'b0;
          cs_n_d     = 1'b0;
          cpol_l_d   = cpol;
          cpha_l_d   = cpha;
          cnt_d      = '0;
          tx_sr_d    = tx_data;
          // Mode with cpha=0 presents the first bit before the first SCLK edge.
          if (!cpha) begin
            dout_d  = head_bit(tx_data);
            tx_sr_d = shift_out(tx_data);
          end
        end
      end
      LEAD: begin
        if (cnt_q == HLast) begin
          state_d = XFER;
          cnt_d   = '0;
          ecnt_d  = EW'(1);
          tick    = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      XFER: begin
        if (cnt_q == HLast) begin
          cnt_d = '0;
          if (ecnt_q == ELast) begin
            state_d = TRAIL;
            sclk_d  = cpol_l_q;
          end else begin
            ecnt_d = ecnt_q + EW'(1);
            tick   = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      TRAIL: begin
        if (cnt_q == HLast) begin
          state_d    = GAP;
          cnt_d      = '0;
          cs_n_d     = 1'b1;
          rx_valid_d = 1'b1;
          rx_data_d  = rx_sr_q;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      GAP: begin
        if (cnt_q == HLast) begin
          state_d    = IDLE;
          cnt_d      = '0;
          tx_ready_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (tick) begin
      sclk_d = ~sclk_q;
      if (cpha_l_q) begin
        drive = ecnt_d[0];
        samp  = ~ecnt_d[0];
      end else begin
        samp  = ecnt_d[0];
        drive = ~ecnt_d[0] && (ecnt_d != ELast);
      end
    end

    if (drive) begin
      dout_d  = head_bit(tx_sr_q);
      tx_sr_d = shift_out(tx_sr_q);
    end

    // Sample edges are 2H apart and RT_DELAY <= H, so one pending capture suffices.
    if (pend_q) begin
      if (dly_q == RLast) begin
        cap    = 1'b1;
        pend_d = 1'b0;
      end else begin
        dly_d = dly_q + CW'(1);
      end
    end
    if (samp) begin
      if (RT_DELAY == 0) begin
        cap = 1'b1;
      end else begin
        pend_d = 1'b1;
        dly_d  = CW'(1);
      end
    end

    if (cap) begin
      rx_sr_d = (MSB_FIRST != 0) ? {rx_sr_q[BITWIDTH-2:0], din_q}
                                 : {din_q, rx_sr_q[BITWIDTH-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      ecnt_q     <= '0;
      cpol_l_q   <= 1'b0;
      cpha_l_q   <= 1'b0;
      tx_sr_q    <= '0;
      rx_sr_q    <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      tx_ready_q <= 1'b0;
      cs_n_q     <= 1'b1;
      sclk_q     <= 1'b0;
      dout_q     <= 1'b0;
      pend_q     <= 1'b0;
      dly_q      <= '0;
      din_q      <= 1'b0;
      pad_clk_q  <= 1'b0;
      pad_cs_n_q <= 1'b1;
      pad_dout_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ecnt_q     <= ecnt_d;
      cpol_l_q   <= cpol_l_d;
      cpha_l_q   <= cpha_l_d;
      tx_sr_q    <= tx_sr_d;
      rx_sr_q    <= rx_sr_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      tx_ready_q <= tx_ready_d;
      cs_n_q     <= cs_n_d;
      sclk_q     <= sclk_d;
      dout_q     <= dout_d;
      pend_q     <= pend_d;
      dly_q      <= dly_d;
      din_q      <= pad_spi_din;
      pad_clk_q  <= sclk_q;
      pad_cs_n_q <= cs_n_q;
      pad_dout_q <= dout_q;
    end
  end

  assign tx_ready       = tx_ready_q;
  assign rx_valid       = rx_valid_q;
  assign rx_data        = rx_data_q;
  assign pad_spi_clk_o  = pad_clk_q;
  assign pad_spi_cs_n_o = pad_cs_n_q;
  assign pad_spi_dout   = pad_dout_q;

endmodule
